lcd_saida_hex: RTL and testbench



---
 rtl/lcd_saida_hex.sv | 169 ++++++++++++++++
 tb/tb_lcd_saida_hex.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/lcd_saida_hex.sv
// rtl/lcd_saida_hex.sv - HD44780 write-only transmitter showing a 32-bit value as hex on line 1
// Optional macro LCD_SIGN_EN: print a sign character and the two's-complement magnitude.
module lcd_saida_hex #(
  parameter int EN_CYCLES     = 16,
  parameter int BYTE_DELAY    = 2000,
  parameter int CLEAR_DELAY   = 82000,
  parameter int POWERUP_DELAY = 750000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] dado,
  input  logic        escreve,
  output logic        pronto,
  output logic        LCD_RS,
  output logic        LCD_RW,
  output logic        LCD_EN,
  output logic [7:0]  LCD_DATA
);

  localparam int MAX_AB = (EN_CYCLES > BYTE_DELAY) ? EN_CYCLES : BYTE_DELAY;
  localparam int MAX_CD = (CLEAR_DELAY > POWERUP_DELAY) ? CLEAR_DELAY : POWERUP_DELAY;
  localparam int MAX_D  = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
  localparam int CW     = $clog2(MAX_D + 1);

`ifdef LCD_SIGN_EN
  localparam logic [3:0] LAST_CHAR = 4'd8;
`else
  localparam logic [3:0] LAST_CHAR = 4'd7;
`endif

  typedef enum logic [2:0] {POWERUP, INIT, IDLE, ADDR, CHARS} state_t;
  typedef enum logic [1:0] {SETUP, PULSE, WAIT} phase_t;

  state_t        state;
  phase_t        phase;
  logic [CW-1:0] cnt;
  logic [3:0]    idx;
  logic [31:0]   valor_r;
  logic [CW-1:0] wait_lim;
  logic [31:0]   disp_val;

  assign LCD_RW = 1'b0;

  // The clear command is the only byte that needs the long settle time.
  assign wait_lim = (!LCD_RS && LCD_DATA == 8'h01) ? CW'(CLEAR_DELAY - 1) : CW'(BYTE_DELAY - 1);

`ifdef LCD_SIGN_EN
  assign disp_val = valor_r[31] ? (~valor_r) + 32'd1 : valor_r;
`else
  assign disp_val = valor_r;
`endif

  function automatic logic [7:0] init_cmd(input logic [1:0] i);
    case (i)
      2'd0:    return 8'h38;
      2'd1:    return 8'h0C;
      2'd2:    return 8'h01;
      default: return 8'h06;
    endcase
  endfunction

  function automatic logic [7:0] hex_ascii(input logic [3:0] n);
    return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
  endfunction

  // Digit i = 0 is the most significant nibble.
  function automatic logic [7:0] digit(input logic [31:0] v, input logic [2:0] i);
    return hex_ascii(v[{~i, 2'b00} +: 4]);
  endfunction

  function automatic logic [7:0] char_byte(input logic [3:0] i, input logic [31:0] v,
                                           input logic neg);
`ifdef LCD_SIGN_EN
    logic [3:0] j;
    j = i - 4'd1;
    if (i == 4'd0) return neg ? 8'h2D : 8'h20;
    return digit(v, j[2:0]);
`else
    if (neg && i[3]) return 8'h00;
    return digit(v, i[2:0]);
`endif
  endfunction

  always_ff @(posedge clock) begin
    if (!reset) begin
      state    <= POWERUP;
      phase    <= SETUP;
      cnt      <= '0;
      idx      <= '0;
      valor_r  <= '0;
      pronto   <= 1'b0;
      LCD_EN   <= 1'b0;
      LCD_RS   <= 1'b0;
      LCD_DATA <= 8'h00;
    end else begin
      case (state)
        POWERUP: begin
          if (cnt == CW'(POWERUP_DELAY - 1)) begin
            cnt      <= '0;
            idx      <= '0;
            state    <= INIT;
            phase    <= SETUP;
            LCD_RS   <= 1'b0;
            LCD_DATA <= init_cmd(2'd0);
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        IDLE: begin
          if (escreve) begin
            valor_r  <= dado;
            pronto   <= 1'b0;
            state    <= ADDR;
            phase    <= SETUP;
            LCD_RS   <= 1'b0;
            LCD_DATA <= 8'h80;
          end
        end
        default: begin
          case (phase)
            SETUP: begin
              phase  <= PULSE;
              LCD_EN <= 1'b1;
              cnt    <= '0;
            end
            PULSE: begin
              if (cnt == CW'(EN_CYCLES - 1)) begin
                LCD_EN <= 1'b0;
                phase  <= WAIT;
                cnt    <= '0;
              end else begin
                cnt <= cnt + 1'b1;
              end
            end
            default: begin
              if (cnt != wait_lim) begin
                cnt <= cnt + 1'b1;
              end else begin
                cnt   <= '0;
                phase <= SETUP;
                if (state == INIT) begin
                  if (idx == 4'd3) begin
                    state  <= IDLE;
                    pronto <= 1'b1;
                  end else begin
                    idx      <= idx + 1'b1;
                    LCD_DATA <= init_cmd(2'(idx + 4'd1));
                  end
                end else if (state == ADDR) begin
                  state    <= CHARS;
                  idx      <= '0;
                  LCD_RS   <= 1'b1;
                  LCD_DATA <= char_byte(4'd0, disp_val, valor_r[31]);
                end else if (idx == LAST_CHAR) begin
                  state  <= IDLE;
                  pronto <= 1'b1;
                end else begin
                  idx      <= idx + 1'b1;
                  LCD_DATA <= char_byte(idx + 4'd1, disp_val, valor_r[31]);
                end
              end
            end
          endcase
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lcd_saida_hex.sv
// tb/tb_lcd_saida_hex.sv - scoreboard bench for lcd_saida_hex (bus bytes, pulse width, pronto timing)
module tb_lcd_saida_hex;

  localparam int EN = 2;
  localparam int BD = 4;
  localparam int CD = 8;
  localparam int PD = 10;
`ifdef LCD_SIGN_EN
  localparam int NB = 10;
`else
  localparam int NB = 9;
`endif
  localparam int INIT_T  = PD + 4 * (1 + EN) + 3 * BD + CD;
  localparam int WRITE_T = NB * (1 + EN + BD);

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] dado = '0;
  logic        escreve = 1'b0;
  logic        pronto;
  logic        LCD_RS, LCD_RW, LCD_EN;
  logic [7:0]  LCD_DATA;

  lcd_saida_hex #(
    .EN_CYCLES(EN), .BYTE_DELAY(BD), .CLEAR_DELAY(CD), .POWERUP_DELAY(PD)
  ) dut (
    .clock(clock), .reset(reset), .dado(dado), .escreve(escreve), .pronto(pronto),
    .LCD_RS(LCD_RS), .LCD_RW(LCD_RW), .LCD_EN(LCD_EN), .LCD_DATA(LCD_DATA)
  );

  always #5 clock = ~clock;

  int ncmp = 0;
  int nerr = 0;
  int cyc  = 0;
  logic [8:0] exp_q[$];

  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    ncmp++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every rising LCD_EN presents one byte; pulse width checked on the fall.
  logic en_q = 1'b0;
  int   width = 0;
  always @(negedge clock) begin
    if (LCD_EN && !en_q) begin
      if (exp_q.size() == 0) begin
        ncmp++;
        nerr++;
        $display("FAIL unexpected_byte: got rs=%b data=%h with nothing expected", LCD_RS, LCD_DATA);
      end else begin
        chk("bus_byte", {23'd0, LCD_RS, LCD_DATA}, {23'd0, exp_q.pop_front()});
      end
      chk("lcd_rw", {31'd0, LCD_RW}, 32'd0);
      width <= 1;
    end else if (LCD_EN) begin
      width <= width + 1;
    end else if (en_q && reset) begin
      chk("en_width", width, EN);
    end
    en_q <= LCD_EN;
  end

  task automatic push(input logic rs, input logic [7:0] d);
    exp_q.push_back({rs, d});
  endtask

  task automatic push_text(input string s);
    for (int i = 0; i < s.len(); i++) push(1'b1, s[i]);
  endtask

  task automatic push_init();
    push(1'b0, 8'h38); push(1'b0, 8'h0C); push(1'b0, 8'h01); push(1'b0, 8'h06);
  endtask

  task automatic push_write(input string us, input string ss);
    push(1'b0, 8'h80);
`ifdef LCD_SIGN_EN
    push_text(ss);
`else
    push_text(us);
`endif
  endtask

  task automatic wait_pronto(input logic lvl, output int at);
    for (int n = 0; n < 3000; n++) begin
      @(negedge clock);
      if (pronto === lvl) break;
    end
    if (pronto !== lvl) chk("pronto_timeout", {31'd0, pronto}, {31'd0, lvl});
    at = cyc;
  endtask

  task automatic do_write(input logic [31:0] v, input string us, input string ss);
    int acc, t;
    dado = v; escreve = 1'b1; acc = cyc + 1;
    push_write(us, ss);
    @(negedge clock);
    escreve = 1'b0; dado = 32'h5A5A_5A5A;
    chk("pronto_fall", {31'd0, pronto}, 32'd0);
    wait_pronto(1'b1, t);
    chk("write_time", t - acc, WRITE_T);
  endtask

  initial begin
    int t, rel, acc, r1, f2, r2;
    repeat (3) @(negedge clock);
    chk("rst_pronto", {31'd0, pronto}, 32'd0);
    chk("rst_en", {31'd0, LCD_EN}, 32'd0);
    chk("rst_rs", {31'd0, LCD_RS}, 32'd0);
    chk("rst_data", {24'd0, LCD_DATA}, 32'd0);
    push_init();
    rel = cyc; reset = 1'b1;
    wait_pronto(1'b1, t);
    chk("init_time", t - rel, INIT_T);

    do_write(32'h1234ABCF, "1234ABCF", " 1234ABCF");

    // Busy: a strobe mid-transfer is dropped.
    dado = 32'hCAFE0019; escreve = 1'b1; acc = cyc + 1;
    push_write("CAFE0019", "-3501FFE7");
    @(negedge clock); escreve = 1'b0; dado = 32'h0;
    repeat (20) @(negedge clock);
    dado = 32'hFFFFFFFF; escreve = 1'b1;
    @(negedge clock); escreve = 1'b0;
    chk("busy_pronto", {31'd0, pronto}, 32'd0);
    wait_pronto(1'b1, t);
    chk("busy_time", t - acc, WRITE_T);

    // Back-to-back with escreve held high.
    dado = 32'h0; escreve = 1'b1;
    push_write("00000000", " 00000000");
    push_write("00000000", " 00000000");
    wait_pronto(1'b0, t);
    wait_pronto(1'b1, r1);
    wait_pronto(1'b0, f2);
    chk("b2b_gap", f2 - r1, 1);
    wait_pronto(1'b1, r2);
    escreve = 1'b0;
    chk("b2b_time", r2 - f2, WRITE_T);
    @(negedge clock);
    chk("b2b_stop", {31'd0, pronto}, 32'd1);

    // Reset during the pulse of character '7'.
    dado = 32'h13579BDF; escreve = 1'b1;
    push(1'b0, 8'h80);
`ifdef LCD_SIGN_EN
    push(1'b1, 8'h20);
`endif
    push_text("1357");
    @(negedge clock); escreve = 1'b0;
    for (int n = 0; n < 500; n++) begin
      @(negedge clock);
      if (LCD_EN && LCD_DATA == 8'h37) break;
    end
    chk("abort_found", {31'd0, LCD_EN}, 32'd1);
    reset = 1'b0;
    @(negedge clock);
    chk("abort_en", {31'd0, LCD_EN}, 32'd0);
    chk("abort_data", {24'd0, LCD_DATA}, 32'd0);
    repeat (2) @(negedge clock);
    push_init();
    rel = cyc; reset = 1'b1;
    wait_pronto(1'b1, t);
    chk("reinit_time", t - rel, INIT_T);

    do_write(32'hFFFFFFFE, "FFFFFFFE", "-00000002");
    do_write(32'h80000000, "80000000", "-80000000");
    do_write(32'hFEDCBA98, "FEDCBA98", "-01234568");

    repeat (20) @(negedge clock);
    chk("queue_empty", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", ncmp, nerr);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
